// File: rtl/hyperbus_trans_splitter.sv
// -----------------------------------------------------------------------------
// hyperbus_trans_splitter
//
// Command-side front end for hyperbus_phy. Accepts one word-burst request of
// arbitrary length and replays it on the PHY trans_* port as a run of
// sub-transactions. Each sub-transaction is at most MAX_BURST words. When
// HYPERBUS_SPLIT_ROW_EN is defined, no sub-transaction crosses a multiple of
// ROW_WORDS. Write and read data do not pass through this block.
//
// Build option:
//   HYPERBUS_SPLIT_ROW_EN  - when defined, chunks are also clipped at row
//                            boundaries. When undefined, ROW_WORDS only takes
//                            part in the parameter sanity check.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i/ready_o request handshake
//   req_address_i       start address, 16-bit word units
//   req_cs_i            one-hot chip select
//   req_write_i         1 = write, 0 = read
//   req_burst_i         length in words (0 is legal, issues nothing)
//   trans_valid_o/ready_i  sub-transaction handshake to the PHY
//   trans_address_o, trans_cs_o, trans_write_o, trans_burst_o
//                       sub-transaction fields
//   req_done_o          one-cycle pulse after the last sub-transaction
//                       (or one cycle after accepting a zero-length request)
//   busy_o              high while issuing
// -----------------------------------------------------------------------------
module hyperbus_trans_splitter #(
  parameter int NR_CS           = 2,
  parameter int BURST_WIDTH     = 12,
  parameter int REQ_BURST_WIDTH = 16,
  parameter int MAX_BURST       = 256,
  parameter int ROW_WORDS       = 512
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [31:0]                req_address_i,
  input  logic [NR_CS-1:0]           req_cs_i,
  input  logic                       req_write_i,
  input  logic [REQ_BURST_WIDTH-1:0] req_burst_i,
  output logic                       trans_valid_o,
  input  logic                       trans_ready_i,
  output logic [31:0]                trans_address_o,
  output logic [NR_CS-1:0]           trans_cs_o,
  output logic                       trans_write_o,
  output logic [BURST_WIDTH-1:0]     trans_burst_o,
  output logic                       req_done_o,
  output logic                       busy_o
);

  // Elaboration-time guard on the parameter ranges the arithmetic relies on.
  if (MAX_BURST < 1 || MAX_BURST > (2 ** BURST_WIDTH) - 1 ||
      ROW_WORDS < 2 || (ROW_WORDS & (ROW_WORDS - 1)) != 0) begin : g_param_err
    $error("hyperbus_trans_splitter: illegal MAX_BURST/BURST_WIDTH/ROW_WORDS");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                     state_reg, state_next;
  logic [31:0]                addr_reg, addr_next;
  logic [REQ_BURST_WIDTH-1:0] rem_reg, rem_next;
  logic [NR_CS-1:0]           cs_reg, cs_next;
  logic                       write_reg, write_next;
  logic                       done_reg, done_next;

  // Chunk size, derived from registered state only so the trans_* outputs
  // hold steady while the PHY stalls.
  logic [31:0]                chunk_w;
  logic [REQ_BURST_WIDTH-1:0] chunk_rem;

`ifdef HYPERBUS_SPLIT_ROW_EN
  localparam int ROW_LOG2 = $clog2(ROW_WORDS);
  // Words left before the next row boundary; one extra bit so a row-aligned
  // address yields the full ROW_WORDS rather than 0.
  logic [ROW_LOG2:0] row_left;
  assign row_left = (ROW_LOG2 + 1)'(ROW_WORDS) - {1'b0, addr_reg[ROW_LOG2-1:0]};
`endif

  always_comb begin
    chunk_w = 32'(rem_reg);
    if (chunk_w > 32'(MAX_BURST)) begin
      chunk_w = 32'(MAX_BURST);
    end
`ifdef HYPERBUS_SPLIT_ROW_EN
    if (chunk_w > 32'(row_left)) begin
      chunk_w = 32'(row_left);
    end
`endif
  end

  assign chunk_rem = chunk_w[REQ_BURST_WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rem_next   = rem_reg;
    cs_next    = cs_reg;
    write_next = write_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid_i) begin
          addr_next  = req_address_i;
          rem_next   = req_burst_i;
          cs_next    = req_cs_i;
          write_next = req_write_i;
          if (req_burst_i == '0) begin
            // Nothing to issue: acknowledge completion immediately.
            done_next = 1'b1;
          end else begin
            state_next = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (trans_ready_i) begin
          // 32-bit add wraps past 0xFFFFFFFF, which is also a row boundary.
          addr_next = addr_reg + chunk_w;
          rem_next  = rem_reg - chunk_rem;
          if (rem_reg == chunk_rem) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      rem_reg   <= '0;
      cs_reg    <= '0;
      write_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      rem_reg   <= rem_next;
      cs_reg    <= cs_next;
      write_reg <= write_next;
      done_reg  <= done_next;
    end
  end

  assign req_ready_o     = (state_reg == IDLE);
  assign trans_valid_o   = (state_reg == ISSUE);
  assign busy_o          = (state_reg == ISSUE);
  assign req_done_o      = done_reg;
  assign trans_address_o = addr_reg;
  assign trans_cs_o      = cs_reg;
  assign trans_write_o   = write_reg;
  assign trans_burst_o   = chunk_w[BURST_WIDTH-1:0];

endmodule

// File: tb/tb_hyperbus_trans_splitter.sv
// -----------------------------------------------------------------------------
// tb_hyperbus_trans_splitter
//
// Drives directed and random requests into hyperbus_trans_splitter and checks
// every sub-transaction against a reference list of (address, length) pairs
// built from the splitting rules with plain arithmetic. Works with
// HYPERBUS_SPLIT_ROW_EN either defined or undefined.
// -----------------------------------------------------------------------------
module tb_hyperbus_trans_splitter;

  localparam int NR_CS           = 2;
  localparam int BURST_WIDTH     = 12;
  localparam int REQ_BURST_WIDTH = 16;
  localparam int MAX_BURST       = 256;
  localparam int ROW_WORDS       = 512;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic                       req_valid_i;
  logic                       req_ready_o;
  logic [31:0]                req_address_i;
  logic [NR_CS-1:0]           req_cs_i;
  logic                       req_write_i;
  logic [REQ_BURST_WIDTH-1:0] req_burst_i;
  logic                       trans_valid_o;
  logic                       trans_ready_i;
  logic [31:0]                trans_address_o;
  logic [NR_CS-1:0]           trans_cs_o;
  logic                       trans_write_o;
  logic [BURST_WIDTH-1:0]     trans_burst_o;
  logic                       req_done_o;
  logic                       busy_o;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk_i = ~clk_i;

  hyperbus_trans_splitter #(
    .NR_CS          (NR_CS),
    .BURST_WIDTH    (BURST_WIDTH),
    .REQ_BURST_WIDTH(REQ_BURST_WIDTH),
    .MAX_BURST      (MAX_BURST),
    .ROW_WORDS      (ROW_WORDS)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_address_i  (req_address_i),
    .req_cs_i       (req_cs_i),
    .req_write_i    (req_write_i),
    .req_burst_i    (req_burst_i),
    .trans_valid_o  (trans_valid_o),
    .trans_ready_i  (trans_ready_i),
    .trans_address_o(trans_address_o),
    .trans_cs_o     (trans_cs_o),
    .trans_write_o  (trans_write_o),
    .trans_burst_o  (trans_burst_o),
    .req_done_o     (req_done_o),
    .busy_o         (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference split of a request into (address, length) pairs.
  logic [31:0] exp_addr_q[$];
  int          exp_len_q[$];

  task automatic build_model(input logic [31:0] addr, input int burst);
    logic [31:0] a;
    int          r;
    int          c;
    a = addr;
    r = burst;
    exp_addr_q.delete();
    exp_len_q.delete();
    while (r > 0) begin
      c = (r < MAX_BURST) ? r : MAX_BURST;
`ifdef HYPERBUS_SPLIT_ROW_EN
      if (c > ROW_WORDS - int'(a % ROW_WORDS)) c = ROW_WORDS - int'(a % ROW_WORDS);
`endif
      exp_addr_q.push_back(a);
      exp_len_q.push_back(c);
      a = a + 32'(c);
      r = r - c;
    end
  endtask

  // Called at a negedge; returns at the negedge right after completion, so a
  // following call exercises back-to-back acceptance.
  // stall_at: chunk index that gets a fixed 5-cycle stall (-1 for none).
  task automatic run_req(input logic [31:0] addr, input int burst, input logic wr,
                         input logic [NR_CS-1:0] cs, input bit rand_stall, input int stall_at);
    int n_stall;
    int k;
    build_model(addr, burst);
    check("req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i   = 1'b1;
    req_address_i = addr;
    req_burst_i   = REQ_BURST_WIDTH'(burst);
    req_write_i   = wr;
    req_cs_i      = cs;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i   = 1'b0;
    req_address_i = $urandom;
    req_burst_i   = REQ_BURST_WIDTH'($urandom);
    if (burst == 0) begin
      check("zero_valid", 32'(trans_valid_o), 32'd0);
      check("zero_done", 32'(req_done_o), 32'd1);
      check("zero_ready", 32'(req_ready_o), 32'd1);
      $display("req addr=0x%08h burst=%0d write=%0d -> no sub-transaction", addr, burst, wr);
      return;
    end
    check("accept_done_low", 32'(req_done_o), 32'd0);
    k = 0;
    while (exp_addr_q.size() > 0) begin
      if (k == stall_at) n_stall = 5;
      else if (rand_stall) n_stall = $urandom_range(0, 2);
      else n_stall = 0;
      // Stall cycles followed by one accepting cycle; outputs must hold.
      for (int s = 0; s <= n_stall; s++) begin
        trans_ready_i = (s == n_stall);
        // Drive random request noise that must be ignored while issuing.
        req_valid_i   = 1'($urandom);
        check("trans_valid", 32'(trans_valid_o), 32'd1);
        check("busy", 32'(busy_o), 32'd1);
        check("req_ready_busy", 32'(req_ready_o), 32'd0);
        check("trans_address", trans_address_o, exp_addr_q[0]);
        check("trans_burst", 32'(trans_burst_o), 32'(exp_len_q[0]));
        check("trans_write", 32'(trans_write_o), 32'(wr));
        check("trans_cs", 32'(trans_cs_o), 32'(cs));
        check("done_mid", 32'(req_done_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
      end
      $display("sub addr=0x%08h burst=%0d write=%0d stalls=%0d",
               exp_addr_q[0], exp_len_q[0], wr, n_stall);
      void'(exp_addr_q.pop_front());
      void'(exp_len_q.pop_front());
      k++;
    end
    trans_ready_i = 1'b0;
    req_valid_i   = 1'b0;
    check("done_pulse", 32'(req_done_o), 32'd1);
    check("ready_after", 32'(req_ready_o), 32'd1);
    check("valid_after", 32'(trans_valid_o), 32'd0);
    $display("req addr=0x%08h burst=%0d write=%0d done after %0d subs", addr, burst, wr, k);
  endtask

  initial begin
    logic [31:0] ra;
    int          rb;
    rst_i         = 1'b1;
    req_valid_i   = 1'b0;
    req_address_i = '0;
    req_cs_i      = '0;
    req_write_i   = 1'b0;
    req_burst_i   = '0;
    trans_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 32'(trans_valid_o), 32'd0);
    check("rst_done", 32'(req_done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_addr", trans_address_o, 32'd0);
    check("rst_burst", 32'(trans_burst_o), 32'd0);
    check("rst_cs", 32'(trans_cs_o), 32'd0);
    check("rst_write", 32'(trans_write_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed scenarios, issued back to back.
    run_req(32'h0000_0000, 32,  1'b0, 2'b01, 1'b0, -1);
    run_req(32'h0000_0100, 600, 1'b1, 2'b10, 1'b0, -1);
    run_req(32'h0000_01F0, 40,  1'b0, 2'b01, 1'b0, -1);
    run_req(32'h0000_0100, 600, 1'b1, 2'b01, 1'b0, 1);
    run_req(32'h0000_0040, 0,   1'b0, 2'b10, 1'b0, -1);
    @(negedge clk_i);
    check("zero_no_valid_later", 32'(trans_valid_o), 32'd0);
    check("zero_done_once", 32'(req_done_o), 32'd0);
    check("zero_ready_stays", 32'(req_ready_o), 32'd1);
    run_req(32'hFFFF_FFF0, 32,  1'b1, 2'b01, 1'b0, -1);
    run_req(32'h0000_01FF, 300, 1'b0, 2'b10, 1'b1, -1);
    @(negedge clk_i);
    check("done_single_cycle", 32'(req_done_o), 32'd0);

    // Reset right after the first handshake of a multi-chunk request.
    build_model(32'h0000_0100, 600);
    req_valid_i   = 1'b1;
    req_address_i = 32'h0000_0100;
    req_burst_i   = 16'd600;
    req_write_i   = 1'b1;
    req_cs_i      = 2'b01;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i   = 1'b0;
    trans_ready_i = 1'b1;
    check("abort_first_addr", trans_address_o, exp_addr_q[0]);
    @(posedge clk_i);
    @(negedge clk_i);
    trans_ready_i = 1'b0;
    rst_i         = 1'b1;
    check("abort_second_addr", trans_address_o, exp_addr_q[1]);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("abort_valid", 32'(trans_valid_o), 32'd0);
    check("abort_ready", 32'(req_ready_o), 32'd1);
    check("abort_done", 32'(req_done_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check("abort_done_later", 32'(req_done_o), 32'd0);
    check("abort_valid_later", 32'(trans_valid_o), 32'd0);
    $display("reset abort after first sub-transaction checked");

    // Random requests clustered near row boundaries and the address wrap.
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 2))
        0:       ra = $urandom;
        1:       ra = ($urandom & 32'hFFFF_FE00) + 32'(512 - $urandom_range(1, 40));
        default: ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 600));
      endcase
      rb = (i % 8 == 7) ? 0 : $urandom_range(1, 900);
      run_req(ra, rb, 1'($urandom), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 1'b1, -1);
    end

    @(negedge clk_i);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
